// File: rtl/stage_io_pkg.sv
// Shared opcode constants for the pipeline stages and the I/O stage helpers.
// Opcode encodings live here only; stages import this package rather than redefining them.
package stage_io_pkg;

   localparam int unsigned OPCODE_MSB = 3;
   localparam int unsigned OP_W       = OPCODE_MSB + 1;

   typedef logic [OPCODE_MSB:0] opcode_t;

   localparam opcode_t OP_NOP   = 4'd0;
   localparam opcode_t OP_INC   = 4'd1;
   localparam opcode_t OP_DEC   = 4'd2;
   localparam opcode_t OP_RIGHT = 4'd3;
   localparam opcode_t OP_LEFT  = 4'd4;
   localparam opcode_t OP_OUT   = 4'd5;
   localparam opcode_t OP_IN    = 4'd6;
   localparam opcode_t OP_JZ    = 4'd7;
   localparam opcode_t OP_JNZ   = 4'd8;

   // Decode helpers used by the I/O stage.
   function automatic logic is_out(input opcode_t op);
      return op == OP_OUT;
   endfunction

   function automatic logic is_in(input opcode_t op);
      return op == OP_IN;
   endfunction

endpackage

// File: rtl/stage_io_fifo.sv
// Output FIFO for the I/O stage: registered head word, power-of-two depth.
// Push while full is honoured only together with a pop in the same cycle.
module stage_io_fifo #(
   parameter int unsigned D_WIDTH = 8,
   parameter int unsigned DEPTH   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic [D_WIDTH-1:0] wd,
   input  logic               pop,
   output logic [D_WIDTH-1:0] rq,
   output logic               empty,
   output logic               full
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [D_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   rd_ptr_next;
   logic [CNT_W-1:0]   count;
   logic               do_push;
   logic               do_pop;
   logic [D_WIDTH-1:0] rq_next;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Head word for the next cycle; bypass the write when it lands on the new head slot.
   always_comb begin
      rd_ptr_next = rd_ptr + PTR_W'(do_pop);
      rq_next     = mem[rd_ptr_next];
      if (do_push && (wr_ptr == rd_ptr_next)) begin
         rq_next = wd;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wd;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rq     <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(do_push);
         rd_ptr <= rd_ptr_next;
         count  <= count + CNT_W'(do_push) - CNT_W'(do_pop);
         rq     <= rq_next;
      end
   end

endmodule

// File: rtl/stage_io.sv
// I/O pipeline stage: passes operations from Modify to DWriteBack, stalls OP_IN until
// external input arrives, and pushes OP_OUT values into an output FIFO.
module stage_io
   import stage_io_pkg::*;
#(
   parameter int unsigned D_WIDTH    = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_MSB:0] operation_in,
   input  logic [D_WIDTH-1:0]  a_in,
   input  logic                drdy_in,
   output logic                ack,
   output logic [OPCODE_MSB:0] operation,
   output logic [D_WIDTH-1:0]  a,
   output logic                drdy,
   input  logic                ack_in,
   output logic [D_WIDTH-1:0]  out_data,
   output logic                out_valid,
   input  logic                out_ready,
   input  logic [D_WIDTH-1:0]  in_data,
   input  logic                in_valid,
   output logic                in_ready
);

   localparam logic [1:0] S_EMPTY   = 2'd0;
   localparam logic [1:0] S_HOLD    = 2'd1;
   localparam logic [1:0] S_WAIT_IN = 2'd2;

   logic [1:0]          state;
   logic [1:0]          state_next;
   opcode_t             op_next;
   logic [D_WIDTH-1:0]  a_next;
   logic                drdy_next;
   logic                accept;
   logic                out_block;
   logic                fifo_push;
   logic                fifo_pop;
   logic                fifo_empty;
   logic                fifo_full;

   assign out_valid = !fifo_empty;
   assign fifo_pop  = out_valid && out_ready;

   // Handshakes and next-state; OP_OUT is refused only when the FIFO cannot take it this edge.
   always_comb begin
      state_next = state;
      op_next    = operation;
      a_next     = a;
      drdy_next  = drdy;
      ack        = 1'b0;
      in_ready   = 1'b0;
      out_block  = is_out(operation_in) && fifo_full && !fifo_pop;

      case (state)
         S_EMPTY:   ack = !out_block;
         S_HOLD:    ack = ack_in && !out_block;
         default:   ack = 1'b0;
      endcase

      accept    = drdy_in && ack;
      fifo_push = accept && is_out(operation_in);

      case (state)
         S_EMPTY: ;
         S_HOLD: begin
            if (ack_in) begin
               state_next = S_EMPTY;
               drdy_next  = 1'b0;
            end
         end
         S_WAIT_IN: begin
            if (in_valid && !reset) begin
               in_ready   = 1'b1;
               a_next     = in_data;
               state_next = S_HOLD;
               drdy_next  = 1'b1;
            end
         end
         default: begin
            state_next = S_EMPTY;
            drdy_next  = 1'b0;
         end
      endcase

      if (accept) begin
         op_next = operation_in;
         if (is_in(operation_in)) begin
            state_next = S_WAIT_IN;
            drdy_next  = 1'b0;
         end else begin
            a_next     = a_in;
            state_next = S_HOLD;
            drdy_next  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_EMPTY;
         operation <= OP_NOP;
         a         <= '0;
         drdy      <= 1'b0;
      end else begin
         state     <= state_next;
         operation <= op_next;
         a         <= a_next;
         drdy      <= drdy_next;
      end
   end

   stage_io_fifo #(
      .D_WIDTH (D_WIDTH),
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .wd    (a_in),
      .pop   (fifo_pop),
      .rq    (out_data),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

endmodule

// File: tb/tb_stage_io.sv
// Directed self-checking bench for stage_io: handshakes, FIFO ordering, input stall, reset.
module tb_stage_io;
   import stage_io_pkg::*;

   localparam int unsigned D_WIDTH    = 8;
   localparam int unsigned FIFO_DEPTH = 4;

   logic                clk = 1'b0;
   logic                reset;
   logic [OPCODE_MSB:0] operation_in;
   logic [D_WIDTH-1:0]  a_in;
   logic                drdy_in;
   logic                ack;
   logic [OPCODE_MSB:0] operation;
   logic [D_WIDTH-1:0]  a;
   logic                drdy;
   logic                ack_in;
   logic [D_WIDTH-1:0]  out_data;
   logic                out_valid;
   logic                out_ready;
   logic [D_WIDTH-1:0]  in_data;
   logic                in_valid;
   logic                in_ready;

   int n_tests = 0;
   int n_fail  = 0;

   stage_io #(
      .D_WIDTH    (D_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .operation_in (operation_in),
      .a_in         (a_in),
      .drdy_in      (drdy_in),
      .ack          (ack),
      .operation    (operation),
      .a            (a),
      .drdy         (drdy),
      .ack_in       (ack_in),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after input changes before checking.
   task automatic settle();
      #1;
   endtask

   initial begin
      reset        = 1'b1;
      operation_in = OP_NOP;
      a_in         = '0;
      drdy_in      = 1'b0;
      ack_in       = 1'b1;
      out_ready    = 1'b0;
      in_data      = '0;
      in_valid     = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      settle();

      // Reset state
      chk("rst_drdy", 32'(drdy), 32'd0);
      chk("rst_ack", 32'(ack), 32'd1);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_operation", 32'(operation), 32'(OP_NOP));
      chk("rst_a", 32'(a), 32'd0);

      // Single pass-through operation, one cycle latency
      tick();
      drdy_in = 1'b1; operation_in = OP_INC; a_in = 8'h05;
      settle();
      chk("inc_ack", 32'(ack), 32'd1);
      tick();
      drdy_in = 1'b0;
      settle();
      chk("inc_drdy", 32'(drdy), 32'd1);
      chk("inc_a", 32'(a), 32'h05);
      chk("inc_op", 32'(operation), 32'(OP_INC));
      chk("inc_out_valid", 32'(out_valid), 32'd0);
      tick();
      settle();
      chk("inc_drain", 32'(drdy), 32'd0);

      // Five OP_OUT into a depth-4 FIFO with the sink stalled
      drdy_in = 1'b1; operation_in = OP_OUT;
      for (int i = 1; i <= 4; i++) begin
         a_in = 8'(i);
         settle();
         chk($sformatf("out_ack_%0d", i), 32'(ack), 32'd1);
         tick();
      end
      a_in = 8'h05;
      settle();
      chk("out_full_ack", 32'(ack), 32'd0);
      chk("out_full_valid", 32'(out_valid), 32'd1);
      chk("out_full_head", 32'(out_data), 32'h01);
      tick();
      settle();
      chk("out_full_drdy", 32'(drdy), 32'd0);
      chk("out_full_ack2", 32'(ack), 32'd0);
      out_ready = 1'b1;
      settle();
      chk("out_pop_ack", 32'(ack), 32'd1);
      tick();
      out_ready = 1'b0; drdy_in = 1'b0;
      settle();
      chk("out5_a", 32'(a), 32'h05);
      chk("out5_drdy", 32'(drdy), 32'd1);
      out_ready = 1'b1;
      for (int k = 2; k <= 5; k++) begin
         settle();
         chk($sformatf("pop_valid_%0d", k), 32'(out_valid), 32'd1);
         chk($sformatf("pop_data_%0d", k), 32'(out_data), 32'(k));
         tick();
      end
      out_ready = 1'b0;
      settle();
      chk("pop_empty", 32'(out_valid), 32'd0);

      // OP_IN stall; in_valid high in the accept cycle must not pulse in_ready
      tick();
      drdy_in = 1'b1; operation_in = OP_IN; a_in = 8'h77; in_valid = 1'b1; in_data = 8'h99;
      settle();
      chk("in_accept_ack", 32'(ack), 32'd1);
      chk("in_accept_in_ready", 32'(in_ready), 32'd0);
      tick();
      drdy_in = 1'b0; in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         settle();
         chk($sformatf("wait_ack_%0d", c), 32'(ack), 32'd0);
         chk($sformatf("wait_drdy_%0d", c), 32'(drdy), 32'd0);
         chk($sformatf("wait_in_ready_%0d", c), 32'(in_ready), 32'd0);
         tick();
      end
      in_valid = 1'b1; in_data = 8'h41;
      settle();
      chk("in_ready_pulse", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      settle();
      chk("in_ready_single", 32'(in_ready), 32'd0);
      chk("in_a", 32'(a), 32'h41);
      chk("in_drdy", 32'(drdy), 32'd1);
      chk("in_op", 32'(operation), 32'(OP_IN));
      tick();

      // Downstream stall for 4 cycles, then zero-bubble reload
      drdy_in = 1'b1; operation_in = OP_DEC; a_in = 8'h10;
      tick();
      operation_in = OP_INC; a_in = 8'h20; ack_in = 1'b0;
      for (int c = 0; c < 4; c++) begin
         settle();
         chk($sformatf("stall_ack_%0d", c), 32'(ack), 32'd0);
         chk($sformatf("stall_drdy_%0d", c), 32'(drdy), 32'd1);
         chk($sformatf("stall_a_%0d", c), 32'(a), 32'h10);
         chk($sformatf("stall_op_%0d", c), 32'(operation), 32'(OP_DEC));
         tick();
      end
      ack_in = 1'b1;
      settle();
      chk("release_ack", 32'(ack), 32'd1);
      tick();
      drdy_in = 1'b0;
      settle();
      chk("reload_drdy", 32'(drdy), 32'd1);
      chk("reload_a", 32'(a), 32'h20);
      chk("reload_op", 32'(operation), 32'(OP_INC));
      tick();
      settle();
      chk("reload_drain", 32'(drdy), 32'd0);

      // Push and pop together while full
      drdy_in = 1'b1; operation_in = OP_OUT;
      for (int i = 1; i <= 4; i++) begin
         a_in = 8'(8'h11 * i);
         tick();
      end
      a_in = 8'hAA; out_ready = 1'b1;
      settle();
      chk("pp_ack", 32'(ack), 32'd1);
      tick();
      out_ready = 1'b0; a_in = 8'hBB;
      settle();
      chk("pp_still_full", 32'(ack), 32'd0);
      drdy_in = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         logic [7:0] exp_v;
         exp_v = (k == 3) ? 8'hAA : 8'(8'h22 + 8'h11 * k);
         settle();
         chk($sformatf("pp_pop_%0d", k), 32'(out_data), 32'(exp_v));
         tick();
      end
      out_ready = 1'b0;
      settle();
      chk("pp_empty", 32'(out_valid), 32'd0);

      // Reset in WAIT_IN with two FIFO entries
      drdy_in = 1'b1; operation_in = OP_OUT; a_in = 8'h01;
      tick();
      a_in = 8'h02;
      tick();
      operation_in = OP_IN;
      tick();
      drdy_in = 1'b0;
      settle();
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      reset = 1'b1; in_valid = 1'b1; in_data = 8'h55;
      settle();
      chk("rst_no_in_ready", 32'(in_ready), 32'd0);
      tick();
      reset = 1'b0; in_valid = 1'b0;
      settle();
      chk("rst2_out_valid", 32'(out_valid), 32'd0);
      chk("rst2_drdy", 32'(drdy), 32'd0);
      chk("rst2_in_ready", 32'(in_ready), 32'd0);
      chk("rst2_ack", 32'(ack), 32'd1);
      chk("rst2_a", 32'(a), 32'd0);
      in_valid = 1'b1;
      settle();
      chk("rst2_no_wait", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global time bound so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed running expected done");
      $fatal(1, "timeout");
   end

endmodule
